// File: rtl/fire_pkg.sv
// Shared encodings for the battleship fire controller.
// Scancodes, cell/result codes, ship count and FSM states.
package fire_pkg;

    localparam int SHIP_CELLS = 17;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    // Index i holds the set-2 make code for letter A+i
    localparam logic [9:0][7:0] LETTER_SC = {
        8'h3B, 8'h43, 8'h33, 8'h34, 8'h2B,
        8'h24, 8'h23, 8'h21, 8'h32, 8'h1C
    };

    // Index i holds the set-2 make code for digit i
    localparam logic [9:0][7:0] DIGIT_SC = {
        8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
        8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
    };

    localparam logic [1:0] CELL_WATER = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    localparam logic [1:0] RES_MISS   = 2'b00;
    localparam logic [1:0] RES_HIT    = 2'b01;
    localparam logic [1:0] RES_REPEAT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        GOT_ROW,
        ARMED,
        READ,
        EVAL,
        WRITE,
        OVER
    } fire_state_t;

endpackage

// File: rtl/scan_to_coord.sv
// Classifies a PS/2 set-2 byte as letter, digit, enter or backspace.
// Letters and digits also yield their 0..9 index.
module scan_to_coord (
    input  logic [7:0] code,
    output logic       is_letter,
    output logic       is_digit,
    output logic       is_enter,
    output logic       is_back,
    output logic [3:0] index
);
    import fire_pkg::*;

    // Table lookup over the letter and digit make codes
    always_comb begin
        is_letter = 1'b0;
        is_digit  = 1'b0;
        is_enter  = (code == SC_ENTER);
        is_back   = (code == SC_BKSP);
        index     = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (code == LETTER_SC[i]) begin
                is_letter = 1'b1;
                index     = 4'(i);
            end
            if (code == DIGIT_SC[i]) begin
                is_digit = 1'b1;
                index    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/fire_controller.sv
// Keyboard-driven shot controller for a two-player battleship game.
// Collects row/column, reads the target cell, writes back and scores.
module fire_controller #(
    parameter int BOARD_SIZE = 10,
    parameter int SHIP_CELLS = fire_pkg::SHIP_CELLS
) (
    input  logic       clock50,
    input  logic       resetN,
    input  logic       scanValid,
    input  logic [7:0] scanCode,
    output logic [3:0] cellRow,
    output logic [3:0] cellCol,
    input  logic [1:0] cellRdata,
    output logic       cellWe,
    output logic [1:0] cellWdata,
    output logic       playerTurn,
    output logic       shotDone,
    output logic [1:0] shotResult,
    output logic [4:0] hitCount0,
    output logic [4:0] hitCount1,
    output logic       gameOver,
    output logic       winner
);
    import fire_pkg::*;

    localparam logic [4:0] SHIP_MAX = 5'(SHIP_CELLS);

    fire_state_t state;
    fire_state_t state_nxt;

    logic       break_q;
    logic       is_letter;
    logic       is_digit;
    logic       is_enter;
    logic       is_back;
    logic [3:0] key_idx;
    logic       idx_ok;
    logic       entry_st;
    logic       key_live;
    logic       letter_key;
    logic       digit_key;
    logic [4:0] fire_cnt;
    logic [4:0] fire_cnt_inc;

    scan_to_coord u_decode (
        .code      (scanCode),
        .is_letter (is_letter),
        .is_digit  (is_digit),
        .is_enter  (is_enter),
        .is_back   (is_back),
        .index     (key_idx)
    );

    assign idx_ok   = (32'(key_idx) < BOARD_SIZE);
    assign entry_st = (state == IDLE) || (state == GOT_ROW) ||
                      (state == ARMED);

    // Only make codes typed during coordinate entry act on the FSM
    assign key_live = scanValid && entry_st && !break_q &&
                      (scanCode != SC_BREAK) && (scanCode != SC_EXT);

    assign letter_key = is_letter && idx_ok;
    assign digit_key  = is_digit && idx_ok;

    assign fire_cnt     = playerTurn ? hitCount1 : hitCount0;
    assign fire_cnt_inc = (fire_cnt < SHIP_MAX) ? fire_cnt + 5'd1
                                                : fire_cnt;

    // Break prefix: swallow the key-release byte that follows F0
    always_ff @(posedge clock50 or negedge resetN) begin
        if (!resetN) begin
            break_q <= 1'b0;
        end else if (scanValid && entry_st && scanCode != SC_EXT) begin
            if (break_q)
                break_q <= 1'b0;
            else if (scanCode == SC_BREAK)
                break_q <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clock50 or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (key_live && letter_key)
                    state_nxt = GOT_ROW;
            end
            GOT_ROW: begin
                if (key_live && is_back)
                    state_nxt = IDLE;
                else if (key_live && digit_key)
                    state_nxt = ARMED;
            end
            ARMED: begin
                if (key_live && is_back)
                    state_nxt = IDLE;
                else if (key_live && letter_key)
                    state_nxt = GOT_ROW;
                else if (key_live && is_enter)
                    state_nxt = READ;
            end
            READ:    state_nxt = EVAL;
            EVAL:    state_nxt = WRITE;
            WRITE:   state_nxt = gameOver ? OVER : IDLE;
            OVER:    state_nxt = OVER;
            default: state_nxt = IDLE;
        endcase
    end

    // Entry registers, shot resolution and scoring
    always_ff @(posedge clock50 or negedge resetN) begin
        if (!resetN) begin
            cellRow    <= 4'd0;
            cellCol    <= 4'd0;
            cellWe     <= 1'b0;
            cellWdata  <= 2'b00;
            playerTurn <= 1'b0;
            shotDone   <= 1'b0;
            shotResult <= 2'b00;
            hitCount0  <= 5'd0;
            hitCount1  <= 5'd0;
            gameOver   <= 1'b0;
            winner     <= 1'b0;
        end else begin
            cellWe   <= 1'b0;
            shotDone <= 1'b0;
            if (key_live && letter_key)
                cellRow <= key_idx;
            if (key_live && digit_key && state != IDLE)
                cellCol <= key_idx;
            if (state == WRITE && !gameOver) begin
                cellRow <= 4'd0;
                cellCol <= 4'd0;
            end
            if (state == EVAL) begin
                shotDone <= 1'b1;
                case (cellRdata)
                    CELL_WATER: begin
                        cellWe     <= 1'b1;
                        cellWdata  <= CELL_MISS;
                        shotResult <= RES_MISS;
                        playerTurn <= ~playerTurn;
                    end
                    CELL_SHIP: begin
                        cellWe     <= 1'b1;
                        cellWdata  <= CELL_HIT;
                        shotResult <= RES_HIT;
                        if (playerTurn)
                            hitCount1 <= fire_cnt_inc;
                        else
                            hitCount0 <= fire_cnt_inc;
                        if (fire_cnt_inc == SHIP_MAX) begin
                            gameOver <= 1'b1;
                            winner   <= playerTurn;
                        end else begin
                            playerTurn <= ~playerTurn;
                        end
                    end
                    default: shotResult <= RES_REPEAT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fire_controller.sv
// Randomized bench for fire_controller with a rule-level game model.
// A small RAM stands in for the opponent board store.
module tb_fire_controller;

    localparam int SHIPS = 17;

    logic       clock50 = 1'b0;
    logic       resetN = 1'b0;
    logic       scanValid = 1'b0;
    logic [7:0] scanCode = 8'h00;
    logic [3:0] cellRow;
    logic [3:0] cellCol;
    logic [1:0] cellRdata;
    logic       cellWe;
    logic [1:0] cellWdata;
    logic       playerTurn;
    logic       shotDone;
    logic [1:0] shotResult;
    logic [4:0] hitCount0;
    logic [4:0] hitCount1;
    logic       gameOver;
    logic       winner;

    fire_controller dut (
        .clock50    (clock50),
        .resetN     (resetN),
        .scanValid  (scanValid),
        .scanCode   (scanCode),
        .cellRow    (cellRow),
        .cellCol    (cellCol),
        .cellRdata  (cellRdata),
        .cellWe     (cellWe),
        .cellWdata  (cellWdata),
        .playerTurn (playerTurn),
        .shotDone   (shotDone),
        .shotResult (shotResult),
        .hitCount0  (hitCount0),
        .hitCount1  (hitCount1),
        .gameOver   (gameOver),
        .winner     (winner)
    );

    always #5 clock50 = ~clock50;

    logic [7:0] lc [10];
    logic [7:0] dc [10];
    logic [1:0] mem [100];
    logic [1:0] init_b [100];
    logic       load_board = 1'b0;

    // Board store: synchronous read, write strobe from the DUT
    always @(posedge clock50) begin
        if (load_board)
            mem <= init_b;
        else if (cellWe)
            mem[int'(cellRow) * 10 + int'(cellCol)] <= cellWdata;
        cellRdata <= mem[int'(cellRow) * 10 + int'(cellCol)];
    end

    int checks = 0;
    int errors = 0;
    int m_turn;
    int m_hits [2];
    int m_over;
    int m_winner;
    int m_result;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_row"}, 32'(cellRow), 0);
        chk({tag, "_col"}, 32'(cellCol), 0);
        chk({tag, "_we"}, 32'(cellWe), 0);
        chk({tag, "_wdata"}, 32'(cellWdata), 0);
        chk({tag, "_turn"}, 32'(playerTurn), 0);
        chk({tag, "_done"}, 32'(shotDone), 0);
        chk({tag, "_result"}, 32'(shotResult), 0);
        chk({tag, "_hc0"}, 32'(hitCount0), 0);
        chk({tag, "_hc1"}, 32'(hitCount1), 0);
        chk({tag, "_over"}, 32'(gameOver), 0);
        chk({tag, "_winner"}, 32'(winner), 0);
    endtask

    task automatic model_reset();
        m_turn = 0;
        m_hits[0] = 0;
        m_hits[1] = 0;
        m_over = 0;
        m_winner = 0;
        m_result = 0;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock50);
        scanValid = 1'b1;
        scanCode = b;
        @(negedge clock50);
        scanValid = 1'b0;
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock50);
            chk({tag, "_done"}, 32'(shotDone), 0);
            chk({tag, "_we"}, 32'(cellWe), 0);
        end
    endtask

    task automatic key_entry(input int r, input int c, input int mode);
        int xr;
        int xc;
        xr = $urandom_range(0, 9);
        xc = $urandom_range(0, 9);
        case (mode)
            0: begin
                send(lc[r]); send(dc[c]);
            end
            1: begin
                send(lc[r]); send(8'hF0); send(lc[r]);
                send(dc[c]); send(8'hF0); send(dc[c]);
            end
            2: begin
                send(lc[xr]); send(dc[xc]);
                send(lc[r]); send(dc[c]);
            end
            3: begin
                send(lc[xr]); send(dc[xc]); send(8'h66);
                send(dc[xc]); send(lc[r]); send(8'hE0);
                send(dc[c]);
            end
            default: begin
                send(lc[xr]); send(lc[r]);
                send(dc[xc]); send(dc[c]);
            end
        endcase
    endtask

    task automatic shot(input int r, input int c, input int mode,
                        input bit noise);
        logic [1:0] pre;
        int exp_we;
        int exp_wd;
        key_entry(r, c, mode);
        pre = mem[r * 10 + c];
        @(negedge clock50);
        scanValid = 1'b1;
        scanCode = 8'h5A;
        @(negedge clock50);
        if (noise)
            scanCode = lc[(r + 3) % 10];
        else
            scanValid = 1'b0;
        chk("read_we", 32'(cellWe), 0);
        chk("read_done", 32'(shotDone), 0);
        chk("read_row", 32'(cellRow), r);
        chk("read_col", 32'(cellCol), c);
        @(negedge clock50);
        if (noise)
            scanCode = 8'hF0;
        chk("eval_we", 32'(cellWe), 0);
        chk("eval_done", 32'(shotDone), 0);
        @(negedge clock50);
        scanValid = 1'b0;
        exp_we = 0;
        exp_wd = 0;
        case (pre)
            2'b00: begin
                exp_we = 1;
                exp_wd = 2;
                m_result = 0;
                m_turn = 1 - m_turn;
            end
            2'b01: begin
                exp_we = 1;
                exp_wd = 3;
                m_result = 1;
                if (m_hits[m_turn] < SHIPS)
                    m_hits[m_turn]++;
                if (m_hits[m_turn] == SHIPS) begin
                    m_over = 1;
                    m_winner = m_turn;
                end else begin
                    m_turn = 1 - m_turn;
                end
            end
            default: m_result = 2;
        endcase
        chk("shot_we", 32'(cellWe), exp_we);
        if (exp_we != 0)
            chk("shot_wdata", 32'(cellWdata), exp_wd);
        chk("shot_done", 32'(shotDone), 1);
        chk("shot_result", 32'(shotResult), m_result);
        chk("shot_turn", 32'(playerTurn), m_turn);
        chk("shot_hc0", 32'(hitCount0), m_hits[0]);
        chk("shot_hc1", 32'(hitCount1), m_hits[1]);
        chk("shot_over", 32'(gameOver), m_over);
        chk("shot_winner", 32'(winner), m_winner);
        chk("shot_row", 32'(cellRow), r);
        chk("shot_col", 32'(cellCol), c);
        @(negedge clock50);
        chk("after_we", 32'(cellWe), 0);
        chk("after_done", 32'(shotDone), 0);
        chk("after_result", 32'(shotResult), m_result);
        if (m_over == 0) begin
            chk("after_row", 32'(cellRow), 0);
            chk("after_col", 32'(cellCol), 0);
        end
    endtask

    function automatic int find_cell(input logic [1:0] v);
        int s;
        s = $urandom_range(0, 99);
        for (int k = 0; k < 100; k++)
            if (mem[(s + k) % 100] == v)
                return (s + k) % 100;
        return -1;
    endfunction

    initial begin
        int placed;
        int idx;
        int guard;
        lc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
               8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
        dc = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        model_reset();

        for (int i = 0; i < 100; i++)
            init_b[i] = 2'b00;
        init_b[1] = 2'b01;
        placed = 0;
        while (placed < 40) begin
            idx = $urandom_range(0, 99);
            if (idx != 67 && idx != 12 && idx != 1 &&
                init_b[idx] == 2'b00) begin
                init_b[idx] = 2'b01;
                placed++;
            end
        end
        load_board = 1'b1;
        @(negedge clock50);
        load_board = 1'b0;
        @(negedge clock50);
        check_zero("por");
        resetN = 1'b1;

        send(dc[3]); send(8'h5A); send(8'hE0); send(8'h66);
        quiet("idle_noise", 3);

        shot(6, 7, 1, 1'b0);
        shot(1, 2, 0, 1'b1);
        shot(0, 1, 0, 1'b0);
        shot(0, 1, 2, 1'b1);

        send(8'h1C); send(8'h66); send(8'h5A);
        quiet("bksp", 5);

        for (int n = 0; n < 16; n++)
            shot($urandom_range(0, 9), $urandom_range(0, 9),
                 $urandom_range(0, 4), 1'($urandom_range(0, 1)));

        guard = 0;
        while (m_over == 0 && guard < 80) begin
            idx = find_cell(m_turn == 0 ? 2'b01 : 2'b00);
            if (idx < 0) begin
                chk("find_cell", 32'(idx), 0);
                guard = 80;
            end else begin
                shot(idx / 10, idx % 10, $urandom_range(0, 4),
                     1'($urandom_range(0, 1)));
                guard++;
            end
        end
        chk("final_over", 32'(gameOver), 1);
        chk("final_winner", 32'(winner), 0);
        chk("final_hc0", 32'(hitCount0), SHIPS);

        idx = find_cell(2'b00);
        send(lc[idx / 10]); send(dc[idx % 10]); send(8'h5A);
        quiet("over_enter", 5);
        chk("over_hold", 32'(gameOver), 1);
        chk("over_hc0", 32'(hitCount0), SHIPS);

        @(negedge clock50);
        resetN = 1'b0;
        #1;
        check_zero("rst1");
        @(negedge clock50);
        resetN = 1'b1;
        model_reset();

        idx = find_cell(2'b00);
        key_entry(idx / 10, idx % 10, 0);
        @(negedge clock50);
        scanValid = 1'b1;
        scanCode = 8'h5A;
        @(negedge clock50);
        scanValid = 1'b0;
        @(negedge clock50);
        resetN = 1'b0;
        #1;
        check_zero("rst_eval");
        @(negedge clock50);
        chk("rst_eval_we", 32'(cellWe), 0);
        resetN = 1'b1;
        quiet("rst_after", 3);
        chk("rst_nowrite", 32'(mem[idx]), 0);
        shot(idx / 10, idx % 10, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
